poly_chunk_mul_pipe: RTL
========================

Name: poly_chunk_mul_pipe

Overview:
- Parametrised successor to the fixed 4-lane public-key/secret-key chunk multiplier.
- Holds one packed chunk of public matrix A and streams a full row of secret-key chunks s against it.
- Each s chunk produces one (2*LANES-1)-coefficient partial product mod 2^COEFF_W, tagged with its index, for the downstream sum/accumulate stage.
- Adds configurable lane count and widths, an optional signed (ternary) secret, full B backpressure, and sequence-error detection.

Parameters:
- LANES, 4, coefficients per packed chunk.
- COEFF_W, 6, A/B coefficient width; all arithmetic is mod 2^COEFF_W.
- S_W, 2, secret coefficient width.
- SECRET_SIGNED, 1, 1 = s coefficients are two's complement; 0 = unsigned.
- IDX_W, 10, index width of A_idx and s_idx.
- DEPTH, 784, row length in coefficients; must be a multiple of LANES.

Ports:
- clk_in  in  1  clock.
- rst_in  in  1  asynchronous active-low reset.
- A_valid  in  1  A chunk offered.
- A_ready  out  1  A chunk accepted when A_valid && A_ready.
- A_idx  in  IDX_W  start index of the A chunk.
- pk_A  in  LANES*COEFF_W  A coefficients; lane 0 in the LSBs.
- s_valid  in  1  s chunk offered.
- s_ready  out  1  s chunk accepted when s_valid && s_ready.
- s_idx  in  IDX_W  start index of the s chunk.
- sk_s  in  LANES*S_W  s coefficients; lane 0 in the LSBs.
- B_valid  out  1  product valid.
- B_ready  in  1  downstream accepts the product.
- idx_B  out  IDX_W+1  A_idx_stored + s_idx, not wrapped.
- B_out  out  (2*LANES-1)*COEFF_W  product coefficients; coefficient 0 in the LSBs.
- seq_err  out  1  sticky sequence-error flag.

Behaviour:
- Reset (rst_in low, asynchronous):
  - a_loaded=0, so A_ready=1.
  - B_valid=0, B_out=0, idx_B=0, seq_err=0, expected-index counter=0.
  - Handshakes are ignored while rst_in is low.
  - Reset mid-operation discards the held A chunk and any pending B.
- States:
  - EMPTY (a_loaded=0): A_ready=1, s_ready=0. On an A handshake, capture pk_A and A_idx; go to LOADED next cycle. s_valid in the same cycle is not accepted.
  - LOADED: A_ready=0. s_ready = !B_valid || B_ready (combinational). One s chunk per cycle at full throughput.
- On an s handshake, the output register loads next edge:
  - B_out coefficient k (0..2*LANES-2) = sum over i+j=k of A_i*s_j, truncated to COEFF_W bits.
  - s_j is sign-extended when SECRET_SIGNED=1, zero-extended otherwise.
  - idx_B = A_idx_stored + s_idx, IDX_W+1 bits.
  - B_valid=1 on that edge, i.e. one cycle latency from s accept.
- B hold and clear:
  - B_out and idx_B stay stable while B_valid && !B_ready.
  - B_valid clears after a B handshake with no new s accept in that cycle.
  - A simultaneous B handshake and s accept replaces the output with no bubble.
- Row end:
  - An accepted s with s_idx == DEPTH-LANES is the last of the row.
  - a_loaded clears next edge, so A_ready=1 one cycle after the last s accept.
  - The pending B stays valid independently of this.
- Sequence check:
  - The expected counter starts at 0 on A load and advances by LANES per accepted s.
  - Any accepted s_idx != expected sets seq_err=1 next edge, sticky until reset.
  - The product is still emitted. The counter follows the accepted s_idx+LANES.
  - The counter returns to 0 at row end.
- Misc:
  - pk_A and sk_s are sampled only on a handshake.
  - All outputs except s_ready are registered.

Test Plan (LANES=4, COEFF_W=6, S_W=2, IDX_W=10, DEPTH=16):
1. Unsigned identity, SECRET_SIGNED=0:
   - Stimulus: A=[1,2,3,4], A_idx=0; s=[1,0,0,0], s_idx=0.
   - Response: one cycle later B_valid=1, B_out=[1,2,3,4,0,0,0], idx_B=0.
2. Signed secret:
   - Stimulus: A=[1,2,3,4]; s=[-1,1,0,0] (2'b11, 2'b01).
   - Response: B_out=[63,63,63,63,4,0,0].
3. Overflow wrap, SECRET_SIGNED=0:
   - Stimulus: A=[63,63,63,63]; s=[1,1,1,1].
   - Response: B_out=[63,62,61,60,61,62,63].
4. Row release:
   - Stimulus: A_idx=12; s_idx 0,4,8,12 back-to-back with B_ready=1.
   - Response: four consecutive B_valid cycles with idx_B=12,16,20,24. A_ready=1 the cycle after s_idx=12 is accepted. seq_err=0.
5. Backpressure:
   - Stimulus: hold B_ready=0 for 3 cycles with s_valid high.
   - Response: s_ready=0, B_out and idx_B stable. When B_ready returns, the next s is accepted with no product lost or duplicated.
6. Sequence error and async reset:
   - Stimulus: s_idx 0 then 8.
   - Response: seq_err=1 the edge after the 8 is accepted, and the product is still emitted.
   - Stimulus: then drive rst_in low mid-cycle while B_valid=1.
   - Response: immediately B_valid=0, seq_err=0, A_ready=1.

Source files
------------

// File: rtl/poly_chunk_mul_pipe.sv
// poly_chunk_mul_pipe: holds one packed chunk of public matrix A and multiplies
// a full row of secret-key chunks against it, one chunk per cycle. Each product
// is a (2*LANES-1)-coefficient schoolbook convolution mod 2^COEFF_W, tagged
// with A_idx + s_idx, and held in a single output register with backpressure.
module poly_chunk_mul_pipe #(
  parameter int LANES         = 4,
  parameter int COEFF_W       = 6,
  parameter int S_W           = 2,
  parameter int SECRET_SIGNED = 1,
  parameter int IDX_W         = 10,
  parameter int DEPTH         = 784
) (
  input  logic                              clk_in,
  input  logic                              rst_in,
  input  logic                              A_valid,
  output logic                              A_ready,
  input  logic [IDX_W-1:0]                  A_idx,
  input  logic [LANES*COEFF_W-1:0]          pk_A,
  input  logic                              s_valid,
  output logic                              s_ready,
  input  logic [IDX_W-1:0]                  s_idx,
  input  logic [LANES*S_W-1:0]              sk_s,
  output logic                              B_valid,
  input  logic                              B_ready,
  output logic [IDX_W:0]                    idx_B,
  output logic [(2*LANES-1)*COEFF_W-1:0]    B_out,
  output logic                              seq_err
);

  localparam int NCOEF = 2 * LANES - 1;
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(DEPTH - LANES);
  localparam logic [IDX_W-1:0] LANE_STEP = IDX_W'(LANES);

  typedef enum logic {
    EMPTY  = 1'b0,
    LOADED = 1'b1
  } state_t;

  state_t state;
  state_t state_nxt;

  logic                          a_hs;
  logic                          s_hs;
  logic                          s_last;
  logic [LANES*COEFF_W-1:0]      a_coef;
  logic [IDX_W-1:0]              a_idx_q;
  logic [IDX_W-1:0]              exp_cnt;
  logic [COEFF_W-1:0]            s_ext [LANES];
  logic [COEFF_W-1:0]            coef  [NCOEF];
  logic [NCOEF*COEFF_W-1:0]      b_nxt;
  logic [IDX_W:0]                idx_nxt;

  assign a_hs    = A_valid && A_ready;
  assign s_hs    = s_valid && s_ready;
  assign s_last  = (s_idx == LAST_IDX);
  assign idx_nxt = {1'b0, a_idx_q} + {1'b0, s_idx};

  // State register: EMPTY waits for an A chunk, LOADED streams the row.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) state <= EMPTY;
    else         state <= state_nxt;
  end

  // Next state: load on an A handshake, release A after the last chunk of the row.
  always_comb begin
    state_nxt = state;
    case (state)
      EMPTY:   if (a_hs) state_nxt = LOADED;
      LOADED:  if (s_hs && s_last) state_nxt = EMPTY;
      default: state_nxt = EMPTY;
    endcase
  end

  // Handshake outputs: s is taken only when the output register is free or draining.
  always_comb begin
    A_ready = (state == EMPTY);
    s_ready = (state == LOADED) && (!B_valid || B_ready);
  end

  // Capture the A chunk and its start index on the A handshake only.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      a_coef  <= '0;
      a_idx_q <= '0;
    end else if (a_hs) begin
      a_coef  <= pk_A;
      a_idx_q <= A_idx;
    end
  end

  // Sequence tracking: the counter follows the accepted index so one slip flags once.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      exp_cnt <= '0;
      seq_err <= 1'b0;
    end else begin
      if (a_hs) begin
        exp_cnt <= '0;
      end else if (s_hs) begin
        if (s_last) exp_cnt <= '0;
        else        exp_cnt <= s_idx + LANE_STEP;
        if (s_idx != exp_cnt) seq_err <= 1'b1;
      end
    end
  end

  // Schoolbook convolution of the held A chunk with the offered s chunk, mod 2^COEFF_W.
  always_comb begin
    logic [S_W-1:0]     s_raw;
    logic [COEFF_W-1:0] a_lane;
    s_raw  = '0;
    a_lane = '0;
    b_nxt  = '0;
    for (int k = 0; k < NCOEF; k++) coef[k] = '0;
    for (int j = 0; j < LANES; j++) begin
      s_raw = sk_s[j*S_W +: S_W];
      if (SECRET_SIGNED != 0) s_ext[j] = COEFF_W'($signed(s_raw));
      else                    s_ext[j] = COEFF_W'(s_raw);
    end
    for (int i = 0; i < LANES; i++) begin
      a_lane = a_coef[i*COEFF_W +: COEFF_W];
      for (int j = 0; j < LANES; j++) begin
        coef[i+j] = coef[i+j] + a_lane * s_ext[j];
      end
    end
    for (int k = 0; k < NCOEF; k++) b_nxt[k*COEFF_W +: COEFF_W] = coef[k];
  end

  // Output register: load on s accept, hold under backpressure, drop valid once drained.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      B_valid <= 1'b0;
      B_out   <= '0;
      idx_B   <= '0;
    end else if (s_hs) begin
      B_valid <= 1'b1;
      B_out   <= b_nxt;
      idx_B   <= idx_nxt;
    end else if (B_ready) begin
      B_valid <= 1'b0;
    end
  end

endmodule
